// File: rtl/lsu_mem_ctrl.sv
// Load/store controller in front of a single-port word memory without byte enables.
// Byte-addressed requests become word accesses; sub-word stores use read-modify-write.
module lsu_mem_ctrl #(
   parameter int addr_p       = 10,
   parameter int data_width_p = 32
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    req_valid_i,
   output logic                    req_ready_o,
   input  logic                    req_we_i,
   input  logic [addr_p+1:0]       req_addr_i,
   input  logic [1:0]              req_size_i,
   input  logic                    req_unsigned_i,
   input  logic [data_width_p-1:0] req_wdata_i,
   output logic                    rsp_valid_o,
   output logic [data_width_p-1:0] rsp_rdata_o,
   output logic                    rsp_err_o,
   output logic [addr_p-1:0]       mem_addr_o,
   output logic                    mem_rd_en_o,
   output logic                    mem_wr_en_o,
   output logic [data_width_p-1:0] mem_data_o,
   input  logic [data_width_p-1:0] mem_data_i
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RD   = 3'd1,
      CAP  = 3'd2,
      WR   = 3'd3,
      RSP  = 3'd4
   } state_t;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;

   state_t                    state_q, state_d;
   logic [addr_p-1:0]         addr_q, addr_d;
   logic [1:0]                lane_q, lane_d;
   logic [1:0]                size_q, size_d;
   logic                      we_q, we_d;
   logic                      uns_q, uns_d;
   logic                      err_q, err_d;
   logic [data_width_p-1:0]   data_q, data_d;

   logic                      accept;
   logic                      misaligned;
   logic [15:0]               shifted;
   logic [data_width_p-1:0]   load_ext;
   logic [data_width_p-1:0]   rep_data;
   logic [data_width_p-1:0]   merged;
   logic [3:0]                byte_sel;

   assign req_ready_o = (state_q == IDLE) && !rst_i;
   assign accept      = req_valid_i && req_ready_o;

   always_comb begin
      misaligned = (req_size_i == 2'b11)
                || ((req_size_i == SIZE_HALF) && req_addr_i[0])
                || ((req_size_i == SIZE_WORD) && (req_addr_i[1:0] != 2'b00));
   end

   // Lane extraction: aligned halves have lane[0] = 0, so one shift serves both sizes.
   always_comb begin
      shifted = 16'(mem_data_i >> {lane_q, 3'b000});
      case (size_q)
         SIZE_BYTE: load_ext = {{24{shifted[7] & ~uns_q}}, shifted[7:0]};
         SIZE_HALF: load_ext = {{16{shifted[15] & ~uns_q}}, shifted[15:0]};
         default:   load_ext = mem_data_i;
      endcase
   end

   assign rep_data = (size_q == SIZE_BYTE) ? {4{data_q[7:0]}} : {2{data_q[15:0]}};

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_merge
         assign byte_sel[gi] = (size_q == SIZE_BYTE) ? (lane_q == 2'(gi))
                                                     : (lane_q[1] == 1'(gi / 2));
         assign merged[8*gi +: 8] = byte_sel[gi] ? rep_data[8*gi +: 8]
                                                 : mem_data_i[8*gi +: 8];
      end
   endgenerate

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      lane_d  = lane_q;
      size_d  = size_q;
      we_d    = we_q;
      uns_d   = uns_q;
      err_d   = err_q;
      data_d  = data_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               addr_d = req_addr_i[addr_p+1:2];
               lane_d = req_addr_i[1:0];
               size_d = req_size_i;
               we_d   = req_we_i;
               uns_d  = req_unsigned_i;
               err_d  = misaligned;
               data_d = req_wdata_i;
               if (misaligned) begin
                  state_d = RSP;
               end else if (req_we_i && (req_size_i == SIZE_WORD)) begin
                  state_d = WR;
               end else begin
                  state_d = RD;
               end
            end
         end
         RD: state_d = CAP;
         CAP: begin
            if (we_q) begin
               data_d  = merged;
               state_d = WR;
            end else begin
               data_d  = load_ext;
               state_d = RSP;
            end
         end
         WR:      state_d = RSP;
         RSP:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         addr_q  <= '0;
         lane_q  <= '0;
         size_q  <= '0;
         we_q    <= 1'b0;
         uns_q   <= 1'b0;
         err_q   <= 1'b0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         lane_q  <= lane_d;
         size_q  <= size_d;
         we_q    <= we_d;
         uns_q   <= uns_d;
         err_q   <= err_d;
         data_q  <= data_d;
      end
   end

   // Response fields read as zero outside the response pulse, and for stores and errors.
   assign rsp_valid_o = (state_q == RSP);
   assign rsp_err_o   = (state_q == RSP) && err_q;
   assign rsp_rdata_o = ((state_q == RSP) && !we_q && !err_q) ? data_q : '0;
   assign mem_addr_o  = addr_q;
   assign mem_rd_en_o = (state_q == RD);
   assign mem_wr_en_o = (state_q == WR);
   assign mem_data_o  = (state_q == WR) ? data_q : '0;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: directed table, busy/back-to-back and reset
// sequences, then random traffic checked against a byte-level reference memory.
module tb_lsu_mem_ctrl;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        req_valid_i = 1'b0;
   logic        req_ready_o;
   logic        req_we_i = 1'b0;
   logic [11:0] req_addr_i = '0;
   logic [1:0]  req_size_i = '0;
   logic        req_unsigned_i = 1'b0;
   logic [31:0] req_wdata_i = '0;
   logic        rsp_valid_o;
   logic [31:0] rsp_rdata_o;
   logic        rsp_err_o;
   logic [9:0]  mem_addr_o;
   logic        mem_rd_en_o;
   logic        mem_wr_en_o;
   logic [31:0] mem_data_o;
   logic [31:0] mem_data_i = '0;

   lsu_mem_ctrl #(.addr_p(10), .data_width_p(32)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_we_i(req_we_i), .req_addr_i(req_addr_i), .req_size_i(req_size_i),
      .req_unsigned_i(req_unsigned_i), .req_wdata_i(req_wdata_i),
      .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
      .mem_addr_o(mem_addr_o), .mem_rd_en_o(mem_rd_en_o), .mem_wr_en_o(mem_wr_en_o),
      .mem_data_o(mem_data_o), .mem_data_i(mem_data_i)
   );

   always #5 clk_i = ~clk_i;

   int n_cmp  = 0;
   int n_fail = 0;
   int wr_count = 0;

   logic [31:0] tb_mem  [1024];
   logic [31:0] ref_mem [1024];

   // Memory with registered read, as the real word memory behaves.
   always @(posedge clk_i) begin
      if (mem_wr_en_o) tb_mem[mem_addr_o] <= mem_data_o;
      if (mem_rd_en_o) mem_data_i <= tb_mem[mem_addr_o];
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h required 0x%08h", name, got, exp);
      end
   endtask

   always @(negedge clk_i) begin
      if (mem_wr_en_o) wr_count++;
      if (!rst_i) begin
         chk("strobe_exclusive", 32'(mem_rd_en_o && mem_wr_en_o), 32'd0);
         if (!rsp_valid_o) chk("idle_rsp_zero", {rsp_rdata_o[30:0], rsp_err_o}, 32'd0);
      end
   end

   typedef struct {
      int          lat;
      logic [31:0] rdata;
      logic        err;
      int          n_rd, n_wr, rd_k, wr_k, busy_bad;
      logic [9:0]  rd_addr, wr_addr;
      logic [31:0] wr_data;
   } obs_t;

   typedef struct {
      logic        we;
      logic [11:0] addr;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
      int          exp_lat;
      logic [31:0] exp_word;
   } vec_t;

   // Reference: byte-lane arithmetic on a word array, independent of any state machine.
   function automatic void model(input logic we, input logic [11:0] addr, input logic [1:0] size,
                                 input logic uns, input logic [31:0] wdata,
                                 output logic [31:0] rdata, output logic err, output int lat,
                                 output logic [31:0] new_word);
      int b  = int'(addr % 4);
      int nb = 1 << size;
      logic [31:0] word = ref_mem[addr / 4];
      longint v;
      err = (size == 2'b11) || ((int'(addr) % nb) != 0);
      lat = 1;
      rdata = '0;
      new_word = word;
      if (err) return;
      if (!we) begin
         v = (longint'(word) >> (8 * b)) % (longint'(1) << (8 * nb));
         if (!uns && nb < 4 && v >= (longint'(1) << (8 * nb - 1)))
            v = v - (longint'(1) << (8 * nb));
         rdata = v[31:0];
         lat = 3;
      end else begin
         for (int i = 0; i < nb; i++) new_word[8*(b+i) +: 8] = wdata[8*i +: 8];
         lat = (nb == 4) ? 2 : 4;
      end
   endfunction

   task automatic do_req(input logic we, input logic [11:0] addr, input logic [1:0] size,
                         input logic uns, input logic [31:0] wdata, output obs_t o);
      int w = 0;
      o = '{default: 0};
      req_we_i = we; req_addr_i = addr; req_size_i = size;
      req_unsigned_i = uns; req_wdata_i = wdata; req_valid_i = 1'b1;
      @(negedge clk_i);
      while (!req_ready_o && w < 20) begin
         @(negedge clk_i);
         w++;
      end
      if (!req_ready_o) begin
         req_valid_i = 1'b0;
         return;
      end
      @(posedge clk_i);
      #1 req_valid_i = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk_i);
         if (mem_rd_en_o) begin o.n_rd++; o.rd_k = k; o.rd_addr = mem_addr_o; end
         if (mem_wr_en_o) begin
            o.n_wr++; o.wr_k = k; o.wr_addr = mem_addr_o; o.wr_data = mem_data_o;
         end
         if (req_ready_o) o.busy_bad++;
         if (rsp_valid_o) begin
            o.lat = k; o.rdata = rsp_rdata_o; o.err = rsp_err_o;
            break;
         end
      end
   endtask

   task automatic run_txn(input string tag, input vec_t v);
      obs_t o;
      int exp_nrd, exp_nwr;
      do_req(v.we, v.addr, v.size, v.uns, v.wdata, o);
      $display("txn %s we=%0b addr=0x%03h size=%0d uns=%0b wdata=%08h -> lat=%0d rdata=%08h err=%0b",
               tag, v.we, v.addr, v.size, v.uns, v.wdata, o.lat, o.rdata, o.err);
      chk({tag, " latency"}, 32'(o.lat), 32'(v.exp_lat));
      chk({tag, " rdata"}, o.rdata, v.exp_rdata);
      chk({tag, " err"}, 32'(o.err), 32'(v.exp_err));
      chk({tag, " ready_low_busy"}, 32'(o.busy_bad), 32'd0);
      exp_nrd = (!v.exp_err && !(v.we && v.size == 2'b10)) ? 1 : 0;
      exp_nwr = (!v.exp_err && v.we) ? 1 : 0;
      chk({tag, " rd_count"}, 32'(o.n_rd), 32'(exp_nrd));
      chk({tag, " wr_count"}, 32'(o.n_wr), 32'(exp_nwr));
      if (exp_nrd == 1) begin
         chk({tag, " rd_cycle"}, 32'(o.rd_k), 32'd1);
         chk({tag, " rd_addr"}, 32'(o.rd_addr), 32'(v.addr[11:2]));
      end
      if (exp_nwr == 1) begin
         chk({tag, " wr_cycle"}, 32'(o.wr_k), (exp_nrd == 1) ? 32'd3 : 32'd1);
         chk({tag, " wr_addr"}, 32'(o.wr_addr), 32'(v.addr[11:2]));
         chk({tag, " wr_data"}, o.wr_data, v.exp_word);
      end
   endtask

   task automatic apply_model(input logic we, input logic [11:0] addr, input logic [1:0] size,
                              input logic uns, input logic [31:0] wdata, output vec_t v);
      model(we, addr, size, uns, wdata, v.exp_rdata, v.exp_err, v.exp_lat, v.exp_word);
      v.we = we; v.addr = addr; v.size = size; v.uns = uns; v.wdata = wdata;
      if (!v.exp_err && we) ref_mem[addr / 4] = v.exp_word;
   endtask

   vec_t tbl[16];

   initial begin
      vec_t v, dummy;
      int acc[$];
      logic [31:0] rsps[$];
      int ready_low;
      logic [31:0] exp_a, exp_b;
      logic [31:0] before_w;
      int wr_base;

      for (int i = 0; i < 1024; i++) begin tb_mem[i] = '0; ref_mem[i] = '0; end

      //             we    addr    size  uns   wdata         rdata         err  lat word
      tbl[0]  = '{1'b1, 12'h010, 2'd2, 1'b0, 32'hDEADBEEF, 32'h00000000, 1'b0, 2, 32'hDEADBEEF};
      tbl[1]  = '{1'b0, 12'h010, 2'd2, 1'b0, 32'h0,        32'hDEADBEEF, 1'b0, 3, 32'h0};
      tbl[2]  = '{1'b0, 12'h013, 2'd0, 1'b0, 32'h0,        32'hFFFFFFDE, 1'b0, 3, 32'h0};
      tbl[3]  = '{1'b0, 12'h013, 2'd0, 1'b1, 32'h0,        32'h000000DE, 1'b0, 3, 32'h0};
      tbl[4]  = '{1'b0, 12'h010, 2'd1, 1'b0, 32'h0,        32'hFFFFBEEF, 1'b0, 3, 32'h0};
      tbl[5]  = '{1'b0, 12'h012, 2'd1, 1'b1, 32'h0,        32'h0000DEAD, 1'b0, 3, 32'h0};
      tbl[6]  = '{1'b0, 12'h010, 2'd0, 1'b0, 32'h0,        32'hFFFFFFEF, 1'b0, 3, 32'h0};
      tbl[7]  = '{1'b1, 12'h011, 2'd0, 1'b0, 32'hABCDEF55, 32'h00000000, 1'b0, 4, 32'hDEAD55EF};
      tbl[8]  = '{1'b0, 12'h010, 2'd2, 1'b0, 32'h0,        32'hDEAD55EF, 1'b0, 3, 32'h0};
      tbl[9]  = '{1'b0, 12'h001, 2'd1, 1'b0, 32'h0,        32'h00000000, 1'b1, 1, 32'h0};
      tbl[10] = '{1'b1, 12'h002, 2'd2, 1'b0, 32'h12345678, 32'h00000000, 1'b1, 1, 32'h0};
      tbl[11] = '{1'b0, 12'h000, 2'd2, 1'b0, 32'h0,        32'h00000000, 1'b0, 3, 32'h0};
      tbl[12] = '{1'b0, 12'h000, 2'd3, 1'b0, 32'h0,        32'h00000000, 1'b1, 1, 32'h0};
      tbl[13] = '{1'b1, 12'h016, 2'd1, 1'b0, 32'hFFFF8001, 32'h00000000, 1'b0, 4, 32'h80010000};
      tbl[14] = '{1'b0, 12'h016, 2'd1, 1'b0, 32'h0,        32'hFFFF8001, 1'b0, 3, 32'h0};
      tbl[15] = '{1'b0, 12'h017, 2'd0, 1'b0, 32'h0,        32'hFFFFFF80, 1'b0, 3, 32'h0};

      // Reset state
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      chk("reset ready", 32'(req_ready_o), 32'd0);
      chk("reset rsp", {rsp_rdata_o[29:0], rsp_valid_o, rsp_err_o}, 32'd0);
      chk("reset strobes", {20'd0, mem_addr_o, mem_rd_en_o, mem_wr_en_o}, 32'd0);
      chk("reset mem_data", mem_data_o, 32'd0);
      @(posedge clk_i);
      #1 rst_i = 1'b0;
      @(negedge clk_i);
      chk("post-reset ready", 32'(req_ready_o), 32'd1);

      // Directed table; the model runs alongside only to keep ref_mem current
      for (int i = 0; i < 16; i++) begin
         apply_model(tbl[i].we, tbl[i].addr, tbl[i].size, tbl[i].uns, tbl[i].wdata, dummy);
         run_txn($sformatf("tbl%0d", i), tbl[i]);
      end

      // Two loads queued with valid held high
      model(1'b0, 12'h010, 2'd2, 1'b0, 32'h0, exp_a, dummy.exp_err, dummy.exp_lat, dummy.exp_word);
      model(1'b0, 12'h013, 2'd0, 1'b1, 32'h0, exp_b, dummy.exp_err, dummy.exp_lat, dummy.exp_word);
      ready_low = 0;
      req_we_i = 1'b0; req_addr_i = 12'h010; req_size_i = 2'd2; req_unsigned_i = 1'b0;
      req_valid_i = 1'b1;
      for (int c = 0; c < 20; c++) begin
         logic acc_now;
         @(negedge clk_i);
         if (rsp_valid_o) rsps.push_back(rsp_rdata_o);
         acc_now = req_valid_i && req_ready_o;
         if (acc.size() == 1 && !req_ready_o) ready_low++;
         @(posedge clk_i);
         if (acc_now) begin
            acc.push_back(c);
            #1;
            if (acc.size() == 1) begin
               req_addr_i = 12'h013; req_size_i = 2'd0; req_unsigned_i = 1'b1;
            end else begin
               req_valid_i = 1'b0;
            end
         end
      end
      req_valid_i = 1'b0;
      $display("txn b2b accepts=%0d spacing=%0d ready_low=%0d responses=%0d",
               acc.size(), (acc.size() >= 2) ? acc[1] - acc[0] : -1, ready_low, rsps.size());
      chk("b2b accepts", 32'(acc.size()), 32'd2);
      chk("b2b spacing", (acc.size() >= 2) ? 32'(acc[1] - acc[0]) : 32'hFFFFFFFF, 32'd4);
      chk("b2b ready_low", 32'(ready_low), 32'd3);
      chk("b2b responses", 32'(rsps.size()), 32'd2);
      chk("b2b rdata0", (rsps.size() >= 1) ? rsps[0] : 32'hXXXXXXXX, exp_a);
      chk("b2b rdata1", (rsps.size() >= 2) ? rsps[1] : 32'hXXXXXXXX, exp_b);

      // Random traffic over a small window so loads see earlier stores
      for (int i = 0; i < 60; i++) begin
         logic        we  = 1'($urandom % 2);
         int          r   = int'($urandom % 8);
         logic [1:0]  sz  = (r < 7) ? 2'(r % 3) : 2'd3;
         logic [11:0] ad  = 12'($urandom_range(0, 63));
         if (($urandom % 4) != 0) begin
            if (sz == 2'd1) ad[0] = 1'b0;
            if (sz == 2'd2) ad[1:0] = 2'b00;
         end
         apply_model(we, ad, sz, 1'($urandom % 2), $urandom, v);
         run_txn($sformatf("rnd%0d", i), v);
      end

      // Reset during CAP of a sub-word store
      before_w = ref_mem[8];
      req_we_i = 1'b1; req_addr_i = 12'h021; req_size_i = 2'd0; req_unsigned_i = 1'b0;
      req_wdata_i = 32'h00000077; req_valid_i = 1'b1;
      @(negedge clk_i);
      chk("rstseq ready before", 32'(req_ready_o), 32'd1);
      @(posedge clk_i);
      #1 req_valid_i = 1'b0;
      wr_base = wr_count;
      @(posedge clk_i);
      #1 rst_i = 1'b1;
      @(posedge clk_i);
      @(negedge clk_i);
      chk("rstseq rsp", {rsp_rdata_o[29:0], rsp_valid_o, rsp_err_o}, 32'd0);
      chk("rstseq strobes", {20'd0, mem_addr_o, mem_rd_en_o, mem_wr_en_o}, 32'd0);
      chk("rstseq mem_data", mem_data_o, 32'd0);
      chk("rstseq ready in reset", 32'(req_ready_o), 32'd0);
      @(posedge clk_i);
      #1 rst_i = 1'b0;
      @(negedge clk_i);
      chk("rstseq ready after", 32'(req_ready_o), 32'd1);
      repeat (4) @(negedge clk_i);
      $display("txn rst_mid_store wr_pulses=%0d word8=%08h", wr_count - wr_base, tb_mem[8]);
      chk("rstseq no write", 32'(wr_count - wr_base), 32'd0);
      chk("rstseq mem unchanged", tb_mem[8], before_w);

      for (int i = 0; i < 16; i++) chk($sformatf("mem word %0d", i), tb_mem[i], ref_mem[i]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store controller that sits directly upstream of the 1024x32 word memory and is its only master.
- Accepts byte-addressed load/store requests from the core over a valid/ready handshake and converts them to word accesses.
- Sub-word stores are done as read-modify-write, because the memory has no byte enables.
- Returns sign- or zero-extended load data and flags misaligned accesses.

Parameters:
- addr_p, 10, word-address width of the memory (byte address is addr_p+2 bits).
- data_width_p, 32, memory word width; only 32 is supported.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- req_valid_i  in  1  request valid
- req_ready_o  out  1  controller can accept a request
- req_we_i  in  1  1 = store, 0 = load
- req_addr_i  in  addr_p+2  byte address
- req_size_i  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal
- req_unsigned_i  in  1  zero-extend loads when 1
- req_wdata_i  in  32  store data, right-aligned
- rsp_valid_o  out  1  one-cycle response pulse
- rsp_rdata_o  out  32  extended load data; 0 for stores and errors
- rsp_err_o  out  1  misaligned or illegal size
- mem_addr_o  out  addr_p  word address, equal to req_addr_i[addr_p+1:2]
- mem_rd_en_o  out  1  memory read strobe
- mem_wr_en_o  out  1  memory write strobe
- mem_data_o  out  32  memory write data
- mem_data_i  in  32  memory read data, valid the cycle after mem_rd_en_o

Behaviour:
- Reset (rst_i high at a clock edge):
  - State goes to IDLE.
  - All registered outputs clear to 0.
  - req_ready_o is 0 while rst_i is high.
  - Any in-flight access is dropped; no mem_wr_en_o is issued after reset asserts.
  - The memory's own active-low reset is tied to ~rst_i at integration.
- States: IDLE, RD, CAP, WR, RSP.
- Handshake:
  - req_ready_o = (state == IDLE) && !rst_i.
  - A transfer occurs when req_valid_i && req_ready_o.
  - All request fields are latched on transfer.
  - Only one request is outstanding; no pipelining.
- Alignment check at accept:
  - An error is raised for: half with addr[0] = 1; word with addr[1:0] != 0; size = 11.
  - Error path is IDLE -> RSP with rsp_err_o = 1 and rsp_rdata_o = 0.
  - No memory strobe is issued on the error path.
- Load path: IDLE -> RD -> CAP -> RSP -> IDLE.
  - RD: mem_rd_en_o = 1.
  - CAP: mem_data_i is valid; the selected lane is extracted and registered.
  - RSP: rsp_valid_o = 1.
  - Latency: rsp_valid_o is high 3 cycles after the accept edge.
- Word store: IDLE -> WR -> RSP.
  - WR: mem_wr_en_o = 1, mem_data_o = wdata.
  - Response 2 cycles after accept.
- Sub-word store: IDLE -> RD -> CAP -> WR -> RSP.
  - CAP merges the new data into the read word.
  - WR writes the merged word.
  - Response 4 cycles after accept.
  - Bytes outside the target lane are written back unchanged.
- Lanes are little-endian:
  - byte lane = addr[1:0], occupying bits 8*lane+7 : 8*lane;
  - half lane = addr[1], occupying the low half when 0 and the high half when 1.
- Extension: byte and half loads are sign-extended from their MSB unless req_unsigned_i = 1.
- Strobes:
  - mem_rd_en_o and mem_wr_en_o are never high in the same cycle.
  - Each is high for exactly one cycle per access.
  - mem_addr_o holds the latched word address from RD through WR.
- Response:
  - rsp_valid_o is a single-cycle pulse with no backpressure; the requester must take it.
  - rsp_rdata_o and rsp_err_o are valid only while rsp_valid_o = 1 and are 0 otherwise.
- req_valid_i while busy is ignored, since req_ready_o = 0; the requester holds the request.
- Back-to-back: a new request can be accepted in the IDLE cycle that follows RSP.
  - Minimum spacing between accepts: 4 cycles for loads, 3 for word stores.

Test Plan:
- Word store then load, unsigned = 0:
  - Store 0xDEADBEEF at byte address 0x010.
  - Required: mem_wr_en_o pulses one cycle after accept with mem_addr_o = 4; rsp_valid_o follows one cycle later.
  - Load word 0x010: rsp_rdata_o = 0xDEADBEEF, 3 cycles after accept.
- Signed and unsigned byte loads from word 0x010 = 0xDEADBEEF:
  - Load byte at 0x013, signed: rsp_rdata_o = 0xFFFFFFDE.
  - Same byte, unsigned: 0x000000DE.
  - Load half at 0x010, signed: 0xFFFFBEEF.
- Sub-word store RMW:
  - Store byte 0x55 at 0x011 over 0xDEADBEEF.
  - Required: strobe order rd, then wr; mem_data_o = 0xDEAD55EF; rsp_valid_o at accept+4.
  - Follow-up word load returns 0xDEAD55EF.
- Misaligned requests:
  - Load half at 0x001, and store word at 0x002.
  - Required: rsp_err_o = 1 and rsp_rdata_o = 0 one cycle after accept; no mem strobes; memory contents unchanged.
- Busy and back-to-back:
  - Hold req_valid_i high with two loads queued.
  - Required: req_ready_o = 0 during RD/CAP/RSP; second accept exactly 4 cycles after the first.
- Reset mid-operation:
  - Assert rst_i during CAP of a sub-word store.
  - Required: no mem_wr_en_o pulse; all outputs 0 on the next cycle; req_ready_o = 1 the cycle after rst_i deasserts.
